// File: rtl/alu_decode_if.sv
// Bus bundle for alu_decode_unit: instruction and operands in,
// decoded controls, ALU result and 7-segment digits out.
interface alu_decode_if;
  logic [31:0] instruction;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        RegDst;
  logic        Jump;
  logic        Branch;
  logic        Bne;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [3:0]  ALUcontrol;
  logic [31:0] ALUresult;
  logic        zero;
  logic [6:0]  seg_first;
  logic [6:0]  seg_second;
  logic [6:0]  seg_third;
  logic [6:0]  seg_fourth;
  logic [6:0]  seg_fifth;

  modport master (
    output instruction, read_data1, read_data2,
    input  RegDst, Jump, Branch, Bne, MemRead, MemtoReg,
    input  MemWrite, ALUSrc, RegWrite, ALUOp, ALUcontrol,
    input  ALUresult, zero,
    input  seg_first, seg_second, seg_third, seg_fourth, seg_fifth
  );

  modport slave (
    input  instruction, read_data1, read_data2,
    output RegDst, Jump, Branch, Bne, MemRead, MemtoReg,
    output MemWrite, ALUSrc, RegWrite, ALUOp, ALUcontrol,
    output ALUresult, zero,
    output seg_first, seg_second, seg_third, seg_fourth, seg_fifth
  );
endinterface

// File: rtl/alu_decode_unit.sv
// MIPS single-cycle main decoder, ALU control, ALU and a
// registered 5-digit hex display of opcode/funct/ALUcontrol.
module alu_decode_unit (
  input  logic         clk,
  input  logic         rst_n,
  alu_decode_if.slave  bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [3:0] AC_AND = 4'b0000;
  localparam logic [3:0] AC_OR  = 4'b0001;
  localparam logic [3:0] AC_ADD = 4'b0010;
  localparam logic [3:0] AC_SUB = 4'b0110;
  localparam logic [3:0] AC_SLT = 4'b0111;
  localparam logic [3:0] AC_NOR = 4'b1100;
  localparam logic [3:0] AC_BAD = 4'b1111;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];
  assign imm    = bus.instruction[15:0];

  logic       reg_dst;
  logic       jump;
  logic       branch;
  logic       bne;
  logic       mem_read;
  logic       mem_to_reg;
  logic       mem_write;
  logic       alu_src;
  logic       reg_write;
  logic [1:0] alu_op;
  logic [3:0] alu_ctl;

  // Main decoder: control lines from opcode
  always_comb begin
    reg_dst    = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    unique case (opcode)
      OP_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OP_BNE: begin
        bne    = 1'b1;
        alu_op = 2'b01;
      end
      OP_ADDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b11;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ALU control: operation select from ALU class, opcode and funct
  always_comb begin
    alu_ctl = AC_BAD;
    unique case (alu_op)
      2'b00: alu_ctl = AC_ADD;
      2'b01: alu_ctl = AC_SUB;
      2'b11: begin
        if (opcode == OP_ANDI)
          alu_ctl = AC_AND;
        else if (opcode == OP_ORI)
          alu_ctl = AC_OR;
      end
      2'b10: begin
        unique case (funct)
          6'h20:   alu_ctl = AC_ADD;
          6'h22:   alu_ctl = AC_SUB;
          6'h24:   alu_ctl = AC_AND;
          6'h25:   alu_ctl = AC_OR;
          6'h27:   alu_ctl = AC_NOR;
          6'h2A:   alu_ctl = AC_SLT;
          default: alu_ctl = AC_BAD;
        endcase
      end
      default: alu_ctl = AC_BAD;
    endcase
  end

  // Logical immediates are zero-extended, arithmetic ones sign-extended
  logic        imm_zext;
  logic [31:0] imm_ext;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;

  assign imm_zext = (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign imm_ext  = imm_zext ? {16'b0, imm}
                             : {{16{imm[15]}}, imm};
  assign op_a     = bus.read_data1;
  assign op_b     = alu_src ? imm_ext : bus.read_data2;

  // ALU datapath; invalid select yields zero
  always_comb begin
    alu_res = 32'd0;
    unique case (alu_ctl)
      AC_AND:  alu_res = op_a & op_b;
      AC_OR:   alu_res = op_a | op_b;
      AC_ADD:  alu_res = op_a + op_b;
      AC_SUB:  alu_res = op_a - op_b;
      AC_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      AC_NOR:  alu_res = ~(op_a | op_b);
      default: alu_res = 32'd0;
    endcase
  end

  assign bus.RegDst     = reg_dst;
  assign bus.Jump       = jump;
  assign bus.Branch     = branch;
  assign bus.Bne        = bne;
  assign bus.MemRead    = mem_read;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.MemWrite   = mem_write;
  assign bus.ALUSrc     = alu_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUOp      = alu_op;
  assign bus.ALUcontrol = alu_ctl;
  assign bus.ALUresult  = alu_res;
  assign bus.zero       = (alu_res == 32'd0);

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] g;
    g = SEG_BLANK;
    unique case (d)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  logic [6:0] seg1_d, seg2_d, seg3_d, seg4_d, seg5_d;
  logic [6:0] seg1_q, seg2_q, seg3_q, seg4_q, seg5_q;

  // Next display glyphs from the current instruction fields
  always_comb begin
    seg1_d = hex7({2'b00, opcode[5:4]});
    seg2_d = hex7(opcode[3:0]);
    seg3_d = hex7({2'b00, funct[5:4]});
    seg4_d = hex7(funct[3:0]);
    seg5_d = hex7(alu_ctl);
  end

  // Display registers; reset blanks every digit at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg1_q <= SEG_BLANK;
      seg2_q <= SEG_BLANK;
      seg3_q <= SEG_BLANK;
      seg4_q <= SEG_BLANK;
      seg5_q <= SEG_BLANK;
    end else begin
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
      seg3_q <= seg3_d;
      seg4_q <= seg4_d;
      seg5_q <= seg5_d;
    end
  end

  assign bus.seg_first  = seg1_q;
  assign bus.seg_second = seg2_q;
  assign bus.seg_third  = seg3_q;
  assign bus.seg_fourth = seg4_q;
  assign bus.seg_fifth  = seg5_q;

endmodule

// File: tb/tb_alu_decode_unit.sv
// Scoreboard bench for alu_decode_unit: directed vectors,
// random instructions, reset/display behaviour.
module tb_alu_decode_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_decode_if bus ();

  alu_decode_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [8:0]  ctl;
    logic [1:0]  op;
    logic [3:0]  ac;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t        qc[$];
  logic [34:0] qs[$];
  int          total = 0;
  int          bad = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. Control vector order:
  // {RegDst,Jump,Branch,Bne,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite}
  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] bb;
    longint      sa, sb;
    int          si;
    opc = ins[31:26];
    fn  = ins[5:0];
    e.ctl = 9'b0;
    e.op  = 2'd0;
    case (opc)
      6'h00: begin e.ctl = 9'b100000001; e.op = 2'd2; end
      6'h23: e.ctl = 9'b000011011;
      6'h2B: e.ctl = 9'b000000110;
      6'h04: begin e.ctl = 9'b001000000; e.op = 2'd1; end
      6'h05: begin e.ctl = 9'b000100000; e.op = 2'd1; end
      6'h08: e.ctl = 9'b000000011;
      6'h0C, 6'h0D: begin e.ctl = 9'b000000011; e.op = 2'd3; end
      6'h02: e.ctl = 9'b010000000;
      default: ;
    endcase
    e.ac = 4'hF;
    if (e.op == 2'd0) e.ac = 4'h2;
    if (e.op == 2'd1) e.ac = 4'h6;
    if (e.op == 2'd3) e.ac = (opc == 6'h0C) ? 4'h0 : 4'h1;
    if (e.op == 2'd2) begin
      if (fn == 6'h20) e.ac = 4'h2;
      if (fn == 6'h22) e.ac = 4'h6;
      if (fn == 6'h24) e.ac = 4'h0;
      if (fn == 6'h25) e.ac = 4'h1;
      if (fn == 6'h27) e.ac = 4'hC;
      if (fn == 6'h2A) e.ac = 4'h7;
    end
    si = int'($signed(ins[15:0]));
    if (!e.ctl[1]) bb = b;
    else if (opc == 6'h0C || opc == 6'h0D) bb = 32'(ins[15:0]);
    else bb = 32'(si);
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
    case (e.ac)
      4'h0: e.res = a & bb;
      4'h1: e.res = a | bb;
      4'h2: e.res = 32'((longint'(a) + longint'(bb)) % 64'h1_0000_0000);
      4'h6: e.res = 32'(longint'(a) + 64'h1_0000_0000 - longint'(bb));
      4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'hC: e.res = ~(a | bb);
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [34:0] seg_model(input logic [31:0] ins,
                                            input logic [3:0] ac);
    return {glyph[{2'b00, ins[31:30]}], glyph[ins[29:26]],
            glyph[{2'b00, ins[5:4]}], glyph[ins[3:0]], glyph[ac]};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus.instruction = ins;
    bus.read_data1  = a;
    bus.read_data2  = b;
    e = model(ins, a, b);
    qc.push_back(e);
    if (rst_n) qs.push_back(seg_model(ins, e.ac));
  endtask

  function automatic logic [34:0] segs();
    return {bus.seg_first, bus.seg_second, bus.seg_third,
            bus.seg_fourth, bus.seg_fifth};
  endfunction

  // Combinational monitor: shortly after each new input set
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (qc.size() > 0) begin
      e = qc.pop_front();
      chk("ctl", {bus.RegDst, bus.Jump, bus.Branch, bus.Bne,
                  bus.MemRead, bus.MemtoReg, bus.MemWrite,
                  bus.ALUSrc, bus.RegWrite}, e.ctl);
      chk("aluop", bus.ALUOp, e.op);
      chk("aluctl", bus.ALUcontrol, e.ac);
      chk("result", bus.ALUresult, e.res);
      chk("zero", bus.zero, e.z);
    end
  end

  // Display monitor: after each clock edge out of reset
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && qs.size() > 0)
      chk("segs", segs(), qs.pop_front());
  end

  function automatic logic [5:0] pick_op(input int k);
    logic [5:0] t [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                          6'h08, 6'h0C, 6'h0D, 6'h02};
    if (k < 9) return t[k];
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic [5:0] pick_fn(input int k);
    logic [5:0] t [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    if (k < 6) return t[k];
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic rand_run(input int n);
    logic [31:0] ins, a, b;
    for (int i = 0; i < n; i++) begin
      ins = $urandom;
      ins[31:26] = pick_op($urandom_range(0, 9));
      ins[5:0] = pick_fn($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      drive(ins, a, b);
    end
  endtask

  localparam logic [34:0] BLANK = {35{1'b1}};

  initial begin
    bus.instruction = 32'd0;
    bus.read_data1  = 32'd0;
    bus.read_data2  = 32'd0;
    #1 rst_n = 1'b0;
    #1 chk("reset_blank", segs(), BLANK);
    // Decode works while display is held in reset
    drive(32'h00221820, 32'd5, 32'd7);
    drive(32'h10220003, 32'd9, 32'd9);
    @(posedge clk);
    #2 chk("reset_hold", segs(), BLANK);
    rst_n = 1'b1;
    drive(32'h00221820, 32'd5, 32'd7);
    @(posedge clk);
    #2;
    chk("seg_first", bus.seg_first, 7'b1000000);
    chk("seg_third", bus.seg_third, 7'b0100100);
    chk("seg_fourth", bus.seg_fourth, 7'b1000000);
    chk("seg_fifth", bus.seg_fifth, 7'b0100100);
    drive(32'h8C430010, 32'h100, 32'hDEAD_BEEF);
    drive(32'hAC22FFFC, 32'h20, 32'h1234_5678);
    drive(32'h0022182A, 32'hFFFF_FFFF, 32'd1);
    drive(32'h3422FFFF, 32'd0, 32'hFFFF_FFFF);
    drive(32'h3022F0F0, 32'hFFFF_00FF, 32'd0);
    drive(32'hFC000000, 32'd3, 32'd4);
    drive(32'h0000003F, 32'd3, 32'd4);
    drive(32'h14220000, 32'd1, 32'd2);
    drive(32'h08020001, 32'hFFFF_FFFF, 32'd0);
    drive(32'h00221822, 32'd0, 32'd1);
    drive(32'h00221827, 32'd0, 32'd0);
    drive(32'h08000000, 32'd0, 32'd0);
    rand_run(300);
    // Mid-cycle reset must blank the display at once
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_blank", segs(), BLANK);
    drive(32'h00221820, 32'd1, 32'd1);
    @(posedge clk);
    #2 chk("async_hold", segs(), BLANK);
    rst_n = 1'b1;
    rand_run(100);
    @(posedge clk);
    #3;
    chk("q_comb_empty", qc.size(), 0);
    chk("q_seg_empty", qs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decode_unit.md
ALU_DECODE_UNIT -- requirements
Module: alu_decode_unit

Interface
REQ-001 The block SHALL have a single clock and reset: clock is asynchronous-free single domain; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for the display registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instruction  input  32  MIPS instruction; opcode=[31:26], funct=[5:0], imm=[15:0].
REQ-005 read_data1 / read_data2  input  32 each  register-file operands A and B.
REQ-006 RegDst, Jump, Branch, Bne, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  output  1 each  main-decoder controls.
REQ-007 ALUOp  output  2  main-decoder ALU class; ALUcontrol  output  4  ALU operation select.
REQ-008 ALUresult  output  32  ALU result; zero  output  1  high when ALUresult==0.
REQ-009 seg_first..seg_fifth  output  7 each  active-low 7-segment digits, bit order {g,f,e,d,c,b,a}.

Function
REQ-010 Main decode (combinational, from opcode), listing fields set to 1, all others 0:
- 0x00 R-type: RegDst, RegWrite, ALUOp=10.
- 0x23 lw: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp=00.
- 0x2B sw: ALUSrc, MemWrite, ALUOp=00.
- 0x04 beq: Branch, ALUOp=01. 0x05 bne: Bne, ALUOp=01.
- 0x08 addi: ALUSrc, RegWrite, ALUOp=00.
- 0x0C andi / 0x0D ori: ALUSrc, RegWrite, ALUOp=11.
- 0x02 j: Jump, ALUOp=00.
- any other opcode: all controls 0, ALUOp=00.
REQ-011 ALUcontrol codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 invalid.
REQ-012 ALU-control decode: ALUOp 00 -> 0010; 01 -> 0110; 11 -> 0000 for opcode 0x0C, 0001 for 0x0D, else 1111.
REQ-013 ALUOp 10 by funct: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x27 -> 1100, 0x2A -> 0111, other -> 1111.
REQ-014 Operand B = read_data2 when ALUSrc=0; else immediate, zero-extended for opcodes 0x0C/0x0D, sign-extended otherwise.
REQ-015 ADD/SUB are 32-bit modulo (wrap, no overflow flag); SLT is signed two's-complement compare giving 32'd1 or 32'd0; NOR = ~(A|B); invalid -> 32'd0.
REQ-016 zero SHALL be 1 exactly when ALUresult==32'd0, including the invalid-op case.
REQ-017 All decode and ALU outputs are combinational; same-cycle response, no clock dependence.
REQ-018 On each rising clk (rst_n high) display registers load hex digits: seg_first=opcode[5:4], seg_second=opcode[3:0], seg_third=funct[5:4], seg_fourth=funct[3:0], seg_fifth=ALUcontrol.
REQ-019 Hex glyphs standard, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-020 rst_n low SHALL immediately (asynchronously) force all five seg outputs to 1111111 (blank) and hold them while low.
REQ-021 Reset SHALL NOT affect combinational decode/ALU outputs; first display update occurs on the first rising clk after rst_n rises.

Verification
REQ-022 add: instruction=0x00221820, A=5, B=7 -> ALUcontrol=0010, ALUresult=12, zero=0, RegDst=RegWrite=1, ALUOp=10.
REQ-023 beq equal: 0x10220003, A=B=9 -> ALUcontrol=0110, ALUresult=0, zero=1, Branch=1, RegWrite=0.
REQ-024 lw: 0x8C430010, A=0x100 -> ALUresult=0x110, MemRead=MemtoReg=ALUSrc=RegWrite=1; sw 0xAC22FFFC, A=0x20 -> ALUresult=0x1C, MemWrite=1.
REQ-025 slt signed: 0x0022182A, A=0xFFFFFFFF, B=1 -> ALUresult=1; ori 0x3422FFFF, A=0 -> ALUresult=0x0000FFFF.
REQ-026 Reset/display: rst_n=0 -> all segs 1111111; release, apply 0x00221820, one clk -> seg_first=1000000, seg_third=0100100, seg_fourth=1000000, seg_fifth=0100100; assert rst_n mid-cycle -> blank immediately.
REQ-027 Unknown opcode 0x3F -> all controls 0, ALUOp=00, ALUcontrol=0010; R-type funct 0x3F -> ALUcontrol=1111, ALUresult=0, zero=1.
